// File: rtl/weight_pingpong_loader.sv
// weight_pingpong_loader: fetches a tile of packed kernels from a fixed-latency weight memory
// into the shadow bank of a ping-pong register file; the consumer promotes it to active with swap.
module weight_pingpong_loader #(
   parameter int Tn           = 4,
   parameter int Tm           = 8,
   parameter int KERNEL_SIZE  = 5,
   parameter int KERNEL_WIDTH = 2,
   parameter int ADDR_WIDTH   = 10,
   parameter int MEM_LATENCY  = 1,
   localparam int KK          = KERNEL_SIZE * KERNEL_SIZE,
   localparam int WORD_W      = KK * KERNEL_WIDTH,
   localparam int DEPTH       = Tn * Tm,
   localparam int CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [CNT_W-1:0]        word_count,
   output logic                    mem_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [WORD_W-1:0]       mem_dout,
   output logic                    busy,
   output logic                    load_done,
   output logic                    shadow_full,
   input  logic                    swap,
   output logic                    weight_valid,
   output logic [DEPTH*WORD_W-1:0] weight_wire
);

   localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                              state, state_nx;
   logic [ADDR_WIDTH-1:0]               base;
   logic [CNT_W-1:0]                    cnt, cnt_m1, iss_cnt, wr_cnt;
   logic [MEM_LATENCY-1:0]              vld_sr;
   logic [1:0][DEPTH-1:0][WORD_W-1:0]   bank;
   logic                                sel, shd;
   logic                                accept, exec_swap, wr_en, last_issue, last_wr, done_nx;

   assign shd        = ~sel;
   assign cnt_m1     = cnt - 1'b1;
   assign accept     = state == IDLE && start && !shadow_full;
   assign exec_swap  = swap && shadow_full;
   assign wr_en      = vld_sr[MEM_LATENCY-1];
   assign last_issue = state == ISSUE && iss_cnt == cnt_m1;
   assign last_wr    = wr_en && wr_cnt == cnt_m1;
   assign done_nx    = (accept && word_count == '0) || last_wr;

   assign mem_en   = state == ISSUE;
   assign mem_addr = mem_en ? base + ADDR_WIDTH'(iss_cnt) : '0;
   assign busy     = state != IDLE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (accept && word_count != '0) ? ISSUE : IDLE;
         ISSUE:   state_nx = last_issue ? DRAIN : ISSUE;
         DRAIN:   state_nx = last_wr ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         base         <= '0;
         cnt          <= '0;
         iss_cnt      <= '0;
         wr_cnt       <= '0;
         vld_sr       <= '0;
         bank         <= '0;
         sel          <= 1'b0;
         shadow_full  <= 1'b0;
         weight_valid <= 1'b0;
         load_done    <= 1'b0;
      end else begin
         state     <= state_nx;
         load_done <= done_nx;
         // shift-in at bit 0; the truncating cast drops the oldest stage
         vld_sr    <= MEM_LATENCY'({vld_sr, mem_en});
         if (accept) begin
            base       <= base_addr;
            cnt        <= (word_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : word_count;
            iss_cnt    <= '0;
            wr_cnt     <= '0;
            bank[shd]  <= '0;
         end
         if (state == ISSUE)
            iss_cnt <= iss_cnt + 1'b1;
         if (wr_en) begin
            bank[shd][wr_cnt[IDX_W-1:0]] <= mem_dout;
            wr_cnt                       <= wr_cnt + 1'b1;
         end
         if (exec_swap) begin
            sel          <= ~sel;
            weight_valid <= 1'b1;
            shadow_full  <= 1'b0;
         end else if (done_nx) begin
            shadow_full  <= 1'b1;
         end
      end
   end

   // kernel elements are presented in reverse order within each word
   for (genvar e = 0; e < DEPTH; e++) begin : g_ent
      for (genvar k = 0; k < KK; k++) begin : g_elem
         assign weight_wire[(e*KK+k)*KERNEL_WIDTH +: KERNEL_WIDTH] =
            bank[sel][e][(KK-1-k)*KERNEL_WIDTH +: KERNEL_WIDTH];
      end
   end

endmodule

// File: tb/tb_weight_pingpong_loader.sv
// tb_weight_pingpong_loader: drives two loaders (memory latency 1 and 3) with shared control
// and checks addresses, timing and tile contents against a tile-level reference model.
module tb_weight_pingpong_loader;

   localparam int KK     = 25;
   localparam int KW     = 2;
   localparam int AW     = 10;
   localparam int WORD_W = 50;
   localparam int DEPTH  = 32;
   localparam int CNT_W  = 6;
   localparam int WW     = DEPTH * WORD_W;

   typedef logic [DEPTH-1:0][WORD_W-1:0] tile_t;

   logic              clk, rst_n, start, swap;
   logic [AW-1:0]     base_addr;
   logic [CNT_W-1:0]  word_count;
   logic              en1, bz1, ld1, sf1, wv1, en3, bz3, ld3, sf3, wv3;
   logic [AW-1:0]     addr1, addr3;
   logic [WORD_W-1:0] dout1, dout3;
   logic [WW-1:0]     ww1, ww3;

   logic [WORD_W-1:0] rom [1024];
   logic [WORD_W-1:0] p1;
   logic [WORD_W-1:0] p3 [3];

   tile_t act_m, shd_m;
   bit    sf_m, valid_m;
   int    nvec, nerr;

   weight_pingpong_loader #(.MEM_LATENCY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
      .mem_en(en1), .mem_addr(addr1), .mem_dout(dout1), .busy(bz1), .load_done(ld1),
      .shadow_full(sf1), .swap(swap), .weight_valid(wv1), .weight_wire(ww1));

   weight_pingpong_loader #(.MEM_LATENCY(3)) u3 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
      .mem_en(en3), .mem_addr(addr3), .mem_dout(dout3), .busy(bz3), .load_done(ld3),
      .shadow_full(sf3), .swap(swap), .weight_valid(wv3), .weight_wire(ww3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous ROMs with 1- and 3-cycle read latency
   always @(posedge clk) begin
      p1    <= rom[addr1];
      p3[0] <= rom[addr3];
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign dout1 = p1;
   assign dout3 = p3[2];

   function automatic logic [WW-1:0] to_wire(tile_t t);
      logic [WW-1:0] w;
      for (int e = 0; e < DEPTH; e++)
         for (int k = 0; k < KK; k++)
            w[(e*KK+k)*KW +: KW] = t[e][(KK-1-k)*KW +: KW];
      return w;
   endfunction

   function automatic tile_t make_tile(logic [AW-1:0] b, int n);
      tile_t         t;
      logic [AW-1:0] a;
      t = '0;
      for (int e = 0; e < (n > DEPTH ? DEPTH : n); e++) begin
         a    = b + AW'(e);
         t[e] = rom[a];
      end
      return t;
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      nvec++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic chk_wire(input string tag, input logic [WW-1:0] o, input logic [WW-1:0] e);
      int idx;
      idx = 0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (o[i*WORD_W +: WORD_W] !== e[i*WORD_W +: WORD_W]) idx = i;
      nvec++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s: entry %0d observed %h expected %h", tag, idx,
                o[idx*WORD_W +: WORD_W], e[idx*WORD_W +: WORD_W]);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_ctl"}, 64'({en1, bz1, ld1, sf1, wv1, en3, bz3, ld3, sf3, wv3}), 64'(0));
      chk({tag, "_addr"}, 64'({addr1, addr3}), 64'(0));
      chk_wire({tag, "_ww1"}, ww1, '0);
      chk_wire({tag, "_ww3"}, ww3, '0);
   endtask

   task automatic do_swap();
      bit sx;
      sx = sf_m;
      @(negedge clk); swap = 1'b1;
      @(negedge clk); swap = 1'b0;
      if (sx) begin act_m = shd_m; valid_m = 1'b1; sf_m = 1'b0; end
      chk_wire("swap_ww1", ww1, to_wire(act_m));
      chk_wire("swap_ww3", ww3, to_wire(act_m));
      chk("swap_flags", 64'({wv1, wv3, sf1, sf3}), 64'({valid_m, valid_m, sf_m, sf_m}));
   endtask

   // start pulse (optionally with a simultaneous swap) and a fixed observation window
   task automatic do_load(input logic [AW-1:0] b, input int n, input bit sw);
      bit            acc, sx;
      int            exp_n, en1_c, en3_c, dc1, dc3, d1, d3, bc1, bc3, abad, wbad;
      logic [AW-1:0] ea;
      logic [WW-1:0] ew;
      tile_t         nt;
      acc   = !sf_m;
      sx    = sw && sf_m;
      exp_n = n > DEPTH ? DEPTH : n;
      {en1_c, en3_c, dc1, dc3, d1, d3, bc1, bc3, abad, wbad} = '0;
      @(negedge clk);
      start = 1'b1; swap = sw; base_addr = b; word_count = CNT_W'(n);
      @(negedge clk);
      start = 1'b0; swap = 1'b0;
      if (sx) begin act_m = shd_m; valid_m = 1'b1; sf_m = 1'b0; end
      nt = make_tile(b, n);
      ew = to_wire(act_m);
      for (int c = 1; c <= 45; c++) begin
         if (en1) begin
            ea = b + AW'(en1_c);
            if (addr1 !== ea || c != en1_c + 1) abad++;
            en1_c++;
         end
         if (en3) begin
            ea = b + AW'(en3_c);
            if (addr3 !== ea || c != en3_c + 1) abad++;
            en3_c++;
         end
         if (ld1) begin dc1++; d1 = c; end
         if (ld3) begin dc3++; d3 = c; end
         if (bz1) bc1++;
         if (bz3) bc3++;
         if (ww1 !== ew || ww3 !== ew || wv1 !== valid_m || wv3 !== valid_m) wbad++;
         @(negedge clk);
      end
      chk("addr_seq", 64'(abad), 64'(0));
      chk("issue_cnt1", 64'(en1_c), 64'(acc ? exp_n : 0));
      chk("issue_cnt3", 64'(en3_c), 64'(acc ? exp_n : 0));
      chk("done_pulses", 64'({dc1, dc3}), acc ? {32'd1, 32'd1} : 64'(0));
      chk("done_cyc1", 64'(d1), 64'(!acc ? 0 : exp_n == 0 ? 1 : exp_n + 2));
      chk("done_cyc3", 64'(d3), 64'(!acc ? 0 : exp_n == 0 ? 1 : exp_n + 4));
      chk("busy_cyc1", 64'(bc1), 64'(acc && exp_n > 0 ? exp_n + 1 : 0));
      chk("busy_cyc3", 64'(bc3), 64'(acc && exp_n > 0 ? exp_n + 3 : 0));
      chk("active_stable", 64'(wbad), 64'(0));
      if (acc) begin shd_m = nt; sf_m = 1'b1; end
      chk("shadow_full", 64'({sf1, sf3}), 64'({sf_m, sf_m}));
   endtask

   initial begin
      logic [WORD_W-1:0] w;
      logic [AW-1:0]     b;
      int                lderr;
      start = 1'b0; swap = 1'b0; base_addr = '0; word_count = '0; rst_n = 1'b0;
      nvec = 0; nerr = 0; lderr = 0;
      for (int a = 0; a < 1024; a++) rom[a] = WORD_W'({$urandom(), $urandom()});
      act_m = '0; shd_m = '0; sf_m = 1'b0; valid_m = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      do_load(10'd0, 32, 1'b0);
      do_swap();
      w = rom[5];
      chk("w5k0", 64'(ww1[(5*KK)*KW +: KW]), 64'(w[WORD_W-1 -: KW]));

      do_load(10'd1020, 8, 1'b0);
      do_swap();

      do_load(10'd100, 32, 1'b0);
      do_swap();
      do_load(10'd300, 32, 1'b0);
      do_swap();
      do_load(10'd500, 32, 1'b0);
      do_load(10'd600, 16, 1'b0);
      do_load(10'd700, 16, 1'b1);

      do_load(10'd50, 0, 1'b0);
      do_swap();
      do_load(10'd200, 40, 1'b0);
      do_swap();

      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 1) do_swap();
         do_load(AW'($urandom()), int'($urandom_range(0, 40)), bit'($urandom_range(0, 1)));
      end
      do_swap();

      b = 10'd900;
      @(negedge clk); start = 1'b1; base_addr = b; word_count = CNT_W'(32);
      @(negedge clk); start = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid_addr", 64'({addr1, addr3}), 64'({b + 10'd9, b + 10'd9}));
      chk("mid_busy", 64'({bz1, bz3}), 64'(2'b11));
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      repeat (3) begin
         @(negedge clk);
         if (ld1 || ld3) lderr++;
      end
      chk("no_done_rst", 64'(lderr), 64'(0));
      check_zero("rst_hold");
      rst_n = 1'b1;
      act_m = '0; shd_m = '0; sf_m = 1'b0; valid_m = 1'b0;
      do_load(10'd333, 20, 1'b0);
      do_swap();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
